mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter P_MEM_BYTES, default 129, giving the number of bytes in the downstream data memory.
REQ-002 SHALL have port i_clk, input, 1 bit: the clock.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port i_clk_enable, input, 1 bit: global step enable, shared with the data memory.
REQ-005 SHALL have port i_req_valid, input, 1 bit: the core presents a load/store request.
REQ-006 SHALL have port i_req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port i_req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port i_req_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port i_req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port i_req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port o_req_ready, output, 1 bit: a request is accepted this cycle.
REQ-012 SHALL have port o_rsp_valid, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have port o_rsp_rdata, output, 32 bits: extended load data.
REQ-014 SHALL have port o_rsp_fault, output, 1 bit: access error, qualified by o_rsp_valid.
REQ-015 SHALL have port o_mem_write, output, 1 bit: data memory write strobe.
REQ-016 SHALL have port o_mem_addr, output, 32 bits: data memory byte address.
REQ-017 SHALL have port o_mem_wdata, output, 32 bits: data memory write word, little-endian.
REQ-018 SHALL have port i_mem_rdata, input, 32 bits: combinational 4-byte read window at o_mem_addr, little-endian.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, MERGE, RESP; state advances only on cycles with i_clk_enable=1, otherwise all registers hold.
REQ-020 SHALL assert o_req_ready only in IDLE; a request is accepted when i_req_valid & o_req_ready & i_clk_enable, latching write, size, unsigned, addr and wdata.
REQ-021 SHALL fault if i_req_size=11 or i_req_addr > P_MEM_BYTES-4 (unsigned compare, no wrap); the FSM goes IDLE->RESP with o_rsp_fault=1 and o_mem_write is never asserted.
REQ-022 SHALL, on a non-faulting accept, go IDLE->ACCESS, driving o_mem_addr = latched addr in ACCESS and MERGE (0 elsewhere).
REQ-023 SHALL, for a load in ACCESS, capture i_mem_rdata and go to RESP.
REQ-024 SHALL, for a word store in ACCESS, assert o_mem_write with o_mem_wdata = latched wdata and go to RESP.
REQ-025 SHALL, for a byte or half store in ACCESS, capture the i_mem_rdata window and go to MERGE.
REQ-026 SHALL, in MERGE, assert o_mem_write with the captured window having [7:0] (byte) or [15:0] (half) replaced from wdata, then go to RESP.
REQ-027 SHALL, in RESP, pulse o_rsp_valid for one enabled cycle and return to IDLE; o_rsp_rdata is valid for loads and 0 for stores.
REQ-028 SHALL extend load data as follows: byte from bit 7, half from bit 15, word unmodified; i_req_unsigned selects zero-extension.
REQ-029 SHALL have a latency from accept to o_rsp_valid of 2 enabled cycles for a load or word store, 3 for a byte/half store, and 1 for a fault.
REQ-030 SHALL assert o_mem_write at most once per request and never outside ACCESS/MERGE.

Reset
REQ-031 SHALL, when i_rst=1 at a clock edge, regardless of i_clk_enable or state, enter IDLE with o_rsp_valid=0, o_rsp_fault=0, o_rsp_rdata=0 and all latched request/window registers cleared.
REQ-032 SHALL drive o_mem_write=0 combinationally while i_rst=1, so a reset in MERGE commits no partial write; the aborted request produces no response.

Structure
REQ-033 SHALL place the size encodings, the FSM state encoding and the default P_MEM_BYTES in shared package mem_pkg.
REQ-034 SHALL use one combinational sub-module, mem_load_ext (size, unsigned, raw word -> extended word), reusable by other load paths.

Verification
REQ-035 SHALL verify: after reset, word load at addr 0x0 -> o_rsp_valid 2 cycles after accept, o_rsp_rdata=0x03020100, fault=0.
REQ-036 SHALL verify: byte store 0x000000AB at addr 0x4 -> one o_mem_write with o_mem_wdata=0x070605AB in MERGE; then a signed byte load at 0x4 -> 0xFFFFFFAB and an unsigned byte load -> 0x000000AB.
REQ-037 SHALL verify: half store 0x00001234 at addr 0x1 -> wdata 0x04031234; then a signed half load at 0x1 -> 0x00001234.
REQ-038 SHALL verify: word load at addr 126 (P_MEM_BYTES=129), and any size=11 request -> o_rsp_valid the next cycle, fault=1, no o_mem_write.
REQ-039 SHALL verify: i_rst asserted while in MERGE -> o_mem_write=0 that cycle, memory word unchanged, o_req_ready=1 the cycle after reset releases.
REQ-040 SHALL verify: i_clk_enable held low for 3 cycles mid-load -> state and outputs frozen, response arrives exactly 3 cycles late.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and defaults for the data memory access path
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_MERGE  = 2'b10,
        ST_RESP   = 2'b11
    } mem_state_e;

    localparam int MEM_BYTES_DEFAULT = 129;

    // The whole 4-byte window must fit; done in 33 bits so addresses near 2^32 cannot wrap.
    function automatic logic out_of_range(input logic [31:0] addr, input int unsigned mem_bytes);
        return ({1'b0, addr} + 33'd4) > 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - sign/zero extension of raw little-endian load data
module mem_load_ext
    import mem_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & i_raw[7]}}, i_raw[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & i_raw[15]}}, i_raw[15:0]};
            default:   o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer with read-modify-write for sub-word stores
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int P_MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_enable,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    mem_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    mem_size_e   size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:8] win_q, win_d;
    logic        fault_q, fault_d;

    logic        accept;
    logic        req_fault;
    logic        sub_word;
    logic [31:0] ext_data;

    assign accept    = i_req_valid & (state_q == ST_IDLE) & i_clk_enable;
    assign req_fault = (i_req_size == SIZE_ILLEGAL) | out_of_range(i_req_addr, P_MEM_BYTES);
    assign sub_word  = (size_q != SIZE_WORD);

    mem_load_ext u_load_ext (
        .i_size     (size_q),
        .i_unsigned (uns_q),
        .i_raw      (i_mem_rdata),
        .o_data     (ext_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            win_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            win_q   <= win_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clk_enable) begin
            case (state_q)
                ST_IDLE:   if (accept) state_d = req_fault ? ST_RESP : ST_ACCESS;
                ST_ACCESS: state_d = (wr_q && sub_word) ? ST_MERGE : ST_RESP;
                ST_MERGE:  state_d = ST_RESP;
                ST_RESP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Request fields are latched on accept; the read window is captured once in ACCESS.
    always_comb begin
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        win_d   = win_q;
        fault_d = fault_q;
        if (accept) begin
            wr_d    = i_req_write;
            size_d  = mem_size_e'(i_req_size);
            uns_d   = i_req_unsigned;
            addr_d  = i_req_addr;
            wdata_d = i_req_wdata;
            rdata_d = '0;
            win_d   = '0;
            fault_d = req_fault;
        end else if (i_clk_enable && state_q == ST_ACCESS) begin
            if (!wr_q) begin
                rdata_d = ext_data;
            end else if (sub_word) begin
                win_d = i_mem_rdata[31:8];
            end
        end
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        o_rsp_valid = (state_q == ST_RESP);
        o_rsp_fault = (state_q == ST_RESP) & fault_q;
        o_rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            ST_ACCESS: begin
                o_mem_addr = addr_q;
                if (wr_q && !sub_word) begin
                    o_mem_write = ~i_rst;
                    o_mem_wdata = wdata_q;
                end
            end
            ST_MERGE: begin
                o_mem_addr  = addr_q;
                o_mem_write = ~i_rst;
                o_mem_wdata = (size_q == SIZE_BYTE) ? {win_q[31:8], wdata_q[7:0]}
                                                    : {win_q[31:16], wdata_q[15:0]};
            end
            default: ;
        endcase
    end

endmodule
